// File: rtl/parity_rx.sv
// Serial parity receiver: after a start strobe, shifts in DATA_WIDTH bits LSB-first,
// then a parity bit. Presents the word with a one-cycle valid pulse and keeps a saturating error count.
module parity_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  ser_in,
    input  logic                  odd_mode,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  parity_err,
    output logic                  busy,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PAR
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_mode;
    logic                  w_accept;
    logic                  w_par_err;

    // In the PAR state ser_in carries the parity bit, so it joins the data in the check.
    assign w_par_err = (^{r_shift, ser_in}) != r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_next = S_PAR;
                end
            end
            S_PAR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_mode     <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_accept) begin
                r_mode    <= odd_mode;
                r_bit_cnt <= '0;
                busy      <= 1'b1;
            end
            if (r_state == S_SHIFT) begin
                r_shift[r_bit_cnt] <= ser_in;
                r_bit_cnt          <= r_bit_cnt + CNT_W'(1);
            end
            if (r_state == S_PAR) begin
                data_out   <= r_shift;
                parity_err <= w_par_err;
                valid      <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

    // A clear on the PAR edge wins over counting that frame's error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if ((r_state == S_PAR) && w_par_err && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule
